// File: rtl/keypad_calc_pkg.sv
// Shared key codes, FSM encoding and key classification for the keypad BCD calculator.
package keypad_calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_BS  = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;

    typedef enum logic [2:0] {
        S_OPA  = 3'd0,
        S_OPB  = 3'd1,
        S_CONV = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_bcd_calc_if.sv
// Key-event input and calculator result bundle between scanner, calculator core and display logic.
interface keypad_bcd_calc_if #(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) ();
    import keypad_calc_pkg::*;

    localparam int RES_W = BIN_W + 2;

    // key_valid is a one-cycle strobe with no back-pressure: the core either
    // accepts the key on that cycle or reports its rejection with key_drop.
    logic                  key_valid;
    logic [3:0]            key_code;
    logic                  busy;
    logic                  done;
    logic                  key_drop;
    logic                  op_sub;
    logic [DIGITS-1:0]     buf_flag_1;
    logic [4*DIGITS-1:0]   key_buf_code_1;
    logic [DIGITS-1:0]     buf_flag_2;
    logic [4*DIGITS-1:0]   key_buf_code_2;
    logic [BIN_W-1:0]      add_1;
    logic [BIN_W-1:0]      add_2;
    logic [RES_W-1:0]      sum;
    state_t                dbg_state;

    modport slave (
        input  key_valid, key_code,
        output busy, done, key_drop, op_sub, buf_flag_1, key_buf_code_1,
               buf_flag_2, key_buf_code_2, add_1, add_2, sum, dbg_state
    );

    modport master (
        output key_valid, key_code,
        input  busy, done, key_drop, op_sub, buf_flag_1, key_buf_code_1,
               buf_flag_2, key_buf_code_2, add_1, add_2, sum, dbg_state
    );

endinterface

// File: rtl/bcd_digit_buffer.sv
// Shift-in BCD operand buffer with per-digit occupancy flags; nibble 0 is the least significant digit.
module bcd_digit_buffer #(
    parameter int DIGITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                clr,
    input  logic [3:0]          digit,
    output logic [4*DIGITS-1:0] buf_code,
    output logic [DIGITS-1:0]   flag,
    output logic                full
);

    assign full = flag[DIGITS-1];

    // clr together with push restarts the buffer holding only the new digit.
    always_ff @(posedge clk) begin
        if (rst || (clr && !push)) begin
            buf_code <= '0;
            flag     <= '0;
        end else if (clr && push) begin
            buf_code <= {{(4*DIGITS-4){1'b0}}, digit};
            flag     <= {{(DIGITS-1){1'b0}}, 1'b1};
        end else if (push && !full) begin
            buf_code <= {buf_code[4*DIGITS-5:0], digit};
            flag     <= {flag[DIGITS-2:0], 1'b1};
        end else if (pop) begin
            buf_code <= buf_code >> 4;
            flag     <= flag >> 1;
        end
    end

endmodule

// File: rtl/keypad_bcd_calc.sv
// Keypad calculator core: collects two BCD operands, converts them to binary and adds or subtracts.
// Optional backspace key support is enabled by defining KEYPAD_BACKSPACE_EN.
module keypad_bcd_calc
    import keypad_calc_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input logic               clk,
    input logic               rst,
    keypad_bcd_calc_if.slave  kif
);

    localparam int RES_W = BIN_W + 2;
    localparam int CNT_W = $clog2(DIGITS);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               kv_q;
    logic [3:0]         kc_q;
    logic               key_is_digit;
    logic               idle_state;
    logic               clr_all;
    logic               push1, push2, pop1, pop2;
    logic               full1, full2;
    logic [3:0]         nib1, nib2;

    function automatic logic [BIN_W-1:0] mul10_add(input logic [BIN_W-1:0] a, input logic [3:0] d);
        return (a << 3) + (a << 1) + BIN_W'(d);
    endfunction

    assign key_is_digit = is_digit(kc_q);
    assign idle_state   = (state == S_OPA) || (state == S_OPB) || (state == S_DONE);
    // A digit after a finished calculation starts a fresh one in operand 1.
    assign clr_all = kv_q && idle_state &&
                     ((kc_q == KEY_CLR) || (key_is_digit && state == S_DONE));
    assign push1   = kv_q && key_is_digit && (state == S_OPA || state == S_DONE);
    assign push2   = kv_q && key_is_digit && (state == S_OPB);
`ifdef KEYPAD_BACKSPACE_EN
    assign pop1    = kv_q && (kc_q == KEY_BS) && (state == S_OPA);
    assign pop2    = kv_q && (kc_q == KEY_BS) && (state == S_OPB);
`else
    assign pop1    = 1'b0;
    assign pop2    = 1'b0;
`endif

    assign nib1 = 4'(kif.key_buf_code_1 >> {cnt, 2'b00});
    assign nib2 = 4'(kif.key_buf_code_2 >> {cnt, 2'b00});
    assign kif.dbg_state = state;

    bcd_digit_buffer #(.DIGITS(DIGITS)) u_buf_1 (
        .clk(clk), .rst(rst), .push(push1), .pop(pop1), .clr(clr_all), .digit(kc_q),
        .buf_code(kif.key_buf_code_1), .flag(kif.buf_flag_1), .full(full1)
    );

    bcd_digit_buffer #(.DIGITS(DIGITS)) u_buf_2 (
        .clk(clk), .rst(rst), .push(push2), .pop(pop2), .clr(clr_all), .digit(kc_q),
        .buf_code(kif.key_buf_code_2), .flag(kif.buf_flag_2), .full(full2)
    );

    // Key events are registered once before the FSM acts on them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_OPA;
            cnt          <= '0;
            kv_q         <= 1'b0;
            kc_q         <= 4'h0;
            kif.busy     <= 1'b0;
            kif.done     <= 1'b0;
            kif.key_drop <= 1'b0;
            kif.op_sub   <= 1'b0;
            kif.add_1    <= '0;
            kif.add_2    <= '0;
            kif.sum      <= '0;
        end else begin
            kv_q         <= kif.key_valid;
            kc_q         <= kif.key_code;
            kif.key_drop <= 1'b0;
            if (clr_all) begin
                state      <= S_OPA;
                kif.busy   <= 1'b0;
                kif.done   <= 1'b0;
                kif.op_sub <= 1'b0;
                kif.add_1  <= '0;
                kif.add_2  <= '0;
                kif.sum    <= '0;
            end else begin
                case (state)
                    S_OPA: if (kv_q) begin
                        if (key_is_digit) begin
                            if (full1) kif.key_drop <= 1'b1;
                        end else if (kc_q == KEY_ADD || kc_q == KEY_SUB) begin
                            kif.op_sub <= (kc_q == KEY_SUB);
                            state      <= S_OPB;
`ifdef KEYPAD_BACKSPACE_EN
                        end else if (kc_q == KEY_BS) begin
                            kif.key_drop <= 1'b0;
`endif
                        end else begin
                            kif.key_drop <= 1'b1;
                        end
                    end
                    S_OPB: if (kv_q) begin
                        if (key_is_digit) begin
                            if (full2) kif.key_drop <= 1'b1;
                        end else if (kc_q == KEY_ADD || kc_q == KEY_SUB) begin
                            kif.op_sub <= (kc_q == KEY_SUB);
                        end else if (kc_q == KEY_EQ) begin
                            state     <= S_CONV;
                            cnt       <= CNT_W'(DIGITS - 1);
                            kif.add_1 <= '0;
                            kif.add_2 <= '0;
                            kif.busy  <= 1'b1;
`ifdef KEYPAD_BACKSPACE_EN
                        end else if (kc_q == KEY_BS) begin
                            kif.key_drop <= 1'b0;
`endif
                        end else begin
                            kif.key_drop <= 1'b1;
                        end
                    end
                    S_CONV: begin
                        kif.key_drop <= kv_q;
                        kif.add_1    <= mul10_add(kif.add_1, nib1);
                        kif.add_2    <= mul10_add(kif.add_2, nib2);
                        if (cnt == '0) state <= S_EXEC;
                        else           cnt   <= cnt - 1'b1;
                    end
                    S_EXEC: begin
                        kif.key_drop <= kv_q;
                        kif.sum <= kif.op_sub
                            ? RES_W'($signed({2'b00, kif.add_1}) - $signed({2'b00, kif.add_2}))
                            : {2'b00, kif.add_1} + {2'b00, kif.add_2};
                        kif.busy <= 1'b0;
                        kif.done <= 1'b1;
                        state    <= S_DONE;
                    end
                    S_DONE: kif.key_drop <= kv_q;
                    default: state <= S_OPA;
                endcase
            end
        end
    end

endmodule
